// File: rtl/jk_pkg.sv
// rtl/jk_pkg.sv - JK cell command encodings shared by the counter and its cells
// Contents: JK_HOLD/JK_CLR/JK_SET/JK_TGL command codes, jk_force() helper.
package jk_pkg;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    // {b, ~b} forces a cell to the value b on the next edge
    function automatic logic [1:0] jk_force(input logic b);
        return {b, ~b};
    endfunction

endpackage

// File: rtl/jk_cell.sv
// rtl/jk_cell.sv - one synchronous-reset JK flip-flop with registered complement
// Ports: clk (clock), rst (sync active-high reset), jk[1:0] ({j,k} command),
//        q (stored bit), qb (registered complement of q).
module jk_cell
    import jk_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] jk,
    output logic       q,
    output logic       qb
);

    // qb is a register of its own rather than an inverter on q, so both
    // outputs change on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            q  <= 1'b0;
            qb <= 1'b1;
        end else begin
            case (jk)
                JK_CLR: begin
                    q  <= 1'b0;
                    qb <= 1'b1;
                end
                JK_SET: begin
                    q  <= 1'b1;
                    qb <= 1'b0;
                end
                JK_TGL: begin
                    q  <= ~q;
                    qb <= q;
                end
                default: begin
                    q  <= q;
                    qb <= qb;
                end
            endcase
        end
    end

endmodule

// File: rtl/jk_updown_counter.sv
// rtl/jk_updown_counter.sv - up/down counter over 0..max built from JK cells
// Ports: clk, rst (sync active-high), en (count enable), up (1=up, 0=down),
//        load/din (parallel load), max (terminal value), q/qb (count and
//        complement, registered), tc (combinational wrap flag).
module jk_updown_counter
    import jk_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] max,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc
);

    logic [WIDTH-1:0][1:0] jk;
    logic                  at_top;
    logic                  at_zero;
    logic                  ones_below;
    logic                  zeros_below;

    // q >= max (not ==) so a value loaded above max wraps in a single step
    assign at_top  = (q >= max);
    assign at_zero = (q == '0);

    always_comb begin
        jk          = '0;
        ones_below  = 1'b1;
        zeros_below = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (load) begin
                jk[i] = jk_force(din[i]);
            end else if (!en) begin
                jk[i] = JK_HOLD;
            end else if (up) begin
                if (at_top)
                    jk[i] = JK_CLR;
                else
                    jk[i] = ones_below ? JK_TGL : JK_HOLD;
            end else begin
                if (at_zero)
                    jk[i] = jk_force(max[i]);
                else
                    jk[i] = zeros_below ? JK_TGL : JK_HOLD;
            end
            // ripple terms: all lower bits 1 (increment carry) / all 0 (borrow)
            ones_below  = ones_below & q[i];
            zeros_below = zeros_below & ~q[i];
        end
    end

    assign tc = en & ~load & ~rst & ((up & at_top) | (~up & at_zero));

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_cell u_cell (
            .clk (clk),
            .rst (rst),
            .jk  (jk[g]),
            .q   (q[g]),
            .qb  (qb[g])
        );
    end

endmodule

// File: tb/tb_jk_updown_counter.sv
// tb/tb_jk_updown_counter.sv - self-checking bench for jk_updown_counter
module tb_jk_updown_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       load = 1'b0;
    logic [3:0] din = '0;
    logic [3:0] max = '0;
    logic [3:0] q;
    logic [3:0] qb;
    logic       tc;

    int tests_run = 0;
    int tests_failed = 0;

    jk_updown_counter #(.WIDTH(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .up   (up),
        .load (load),
        .din  (din),
        .max  (max),
        .q    (q),
        .qb   (qb),
        .tc   (tc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // one rising edge, then settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // settle combinational outputs after an input change
    task automatic settle();
        #1;
    endtask

    int m;
    int exp_tc;
    int exp_seq[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

    initial begin
        // reset; tc must stay 0 under rst even when it would otherwise wrap
        rst = 1; en = 1; up = 1; max = 0;
        settle();
        check("tc_in_reset", int'(tc), 0);
        tick();
        check("reset_q", int'(q), 0);
        check("reset_qb", int'(qb), 15);
        check("tc_in_reset_after", int'(tc), 0);

        // count up to 9 and wrap
        rst = 0; max = 9; up = 1; en = 1;
        for (int k = 0; k < 12; k++) begin
            settle();
            check($sformatf("up_tc_%0d", k), int'(tc), (k == 9) ? 1 : 0);
            tick();
            check($sformatf("up_q_%0d", k), int'(q), exp_seq[k]);
        end

        // count down from 0 reloads max
        rst = 1; tick(); rst = 0;
        up = 0;
        settle();
        check("dn_tc_at0", int'(tc), 1);
        tick();
        check("dn_q9", int'(q), 9);
        check("dn_tc_at9", int'(tc), 0);
        tick();
        check("dn_q8", int'(q), 8);
        tick();
        check("dn_q7", int'(q), 7);

        // load above max, then wrap up in one step; reload and count down
        load = 1; din = 13; up = 1;
        settle();
        check("ld_tc", int'(tc), 0);
        tick();
        check("ld_q13", int'(q), 13);
        check("ld_qb", int'(qb), 2);
        load = 0;
        settle();
        check("above_tc", int'(tc), 1);
        tick();
        check("above_wrap", int'(q), 0);
        load = 1; tick();
        load = 0; up = 0;
        settle();
        check("above_dn_tc", int'(tc), 0);
        tick();
        check("above_dn_q12", int'(q), 12);

        // rst beats load on the same edge
        load = 1; din = 5; tick();
        check("pre_q5", int'(q), 5);
        din = 2; rst = 1; en = 1;
        tick();
        check("rst_over_ld_q", int'(q), 0);
        check("rst_over_ld_qb", int'(qb), 15);
        rst = 0;
        tick();
        check("ld_after_rst", int'(q), 2);
        load = 0;

        // max == 0 pins q at 0 in both directions
        max = 0;
        for (int k = 0; k < 4; k++) begin
            up = (k < 2);
            settle();
            check($sformatf("max0_tc_%0d", k), int'(tc), 1);
            tick();
            check($sformatf("max0_q_%0d", k), int'(q), 0);
        end

        // full-range max
        max = 15; load = 1; din = 14; tick();
        load = 0; up = 1;
        settle();
        check("max15_tc14", int'(tc), 0);
        tick();
        check("max15_q15", int'(q), 15);
        settle();
        check("max15_tc15", int'(tc), 1);
        tick();
        check("max15_q0", int'(q), 0);
        check("max15_qb", int'(qb), 15);

        // random en/up (plus rare load/rst) against a reference model
        max = 9;
        m = 0;
        for (int k = 0; k < 500; k++) begin
            en   = 1'($urandom_range(0, 1));
            if ((k % 40) == 0) up = ~up;
            load = ($urandom_range(0, 31) == 0);
            rst  = ($urandom_range(0, 63) == 0);
            din  = 4'($urandom_range(0, 15));
            settle();
            exp_tc = (en && !load && !rst && ((up && m >= 9) || (!up && m == 0))) ? 1 : 0;
            check($sformatf("rnd_tc_%0d", k), int'(tc), exp_tc);
            if (rst)       m = 0;
            else if (load) m = int'(din);
            else if (en) begin
                if (up) m = (m >= 9) ? 0 : m + 1;
                else    m = (m == 0) ? 9 : m - 1;
            end
            tick();
            check($sformatf("rnd_q_%0d", k), int'(q), m);
            check($sformatf("rnd_qb_%0d", k), int'(qb), (~m) & 15);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
